// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S link blocks (capture and play).
//   I2S_WORD_W   : default bits per channel word.
//   cap_state_e  : capture alignment state (ALIGN, LEFT, RIGHT).
// -----------------------------------------------------------------------------
package i2s_pkg;

  localparam int I2S_WORD_W = 16;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } cap_state_e;

endpackage

// File: rtl/i2s_capture_if.sv
// -----------------------------------------------------------------------------
// i2s_capture_if
// Output bus of the I2S capture block.
//   left_data/right_data : captured pair
//   valid/ready          : pair handshake
//   overrun              : sticky drop flag
//   state                : capture state, debug visibility only
// Handshake: the pair is transferred on a cycle where valid && ready. Once
// valid is high, left_data/right_data hold steady until that transfer; a new
// pair may be loaded in the transfer cycle itself, keeping valid high.
// master = capture block, slave = consumer.
// -----------------------------------------------------------------------------
interface i2s_capture_if
  import i2s_pkg::*;
#(
  parameter int WORD_W = I2S_WORD_W
) ();

  logic [WORD_W-1:0] left_data;
  logic [WORD_W-1:0] right_data;
  logic              valid;
  logic              ready;
  logic              overrun;
  cap_state_e        state;

  modport master (
    output left_data, right_data, valid, overrun, state,
    input  ready
  );

  modport slave (
    input  left_data, right_data, valid, overrun, state,
    output ready
  );

endinterface

// File: rtl/i2s_sync.sv
// -----------------------------------------------------------------------------
// i2s_sync
// STAGES-deep synchronizer for one asynchronous bit.
//   clk, reset : system clock, synchronous active-high reset
//   d          : asynchronous input
//   q          : synchronized level (RISE_EN = 0), or a one-clk pulse on each
//                synchronized 0->1 transition (RISE_EN = 1)
// -----------------------------------------------------------------------------
module i2s_sync #(
  parameter int STAGES  = 2,
  parameter bit RISE_EN = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], d};
  end

  generate
    if (RISE_EN) begin : g_rise
      logic r_prev;
      always_ff @(posedge clk) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= r_sync[STAGES-1];
      end
      assign q = r_sync[STAGES-1] & ~r_prev;
    end else begin : g_level
      assign q = r_sync[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/i2s_capture.sv
// -----------------------------------------------------------------------------
// i2s_capture
// Slave-mode I2S receiver. Oversamples sclk/ws/sdi in the clk domain, aligns
// to the ws edge, deserializes MSB-first left/right words and presents each
// completed pair on a valid/ready bus.
//   clk, reset     : system clock, synchronous active-high reset
//   sclk, ws, sdi  : external I2S link (asynchronous)
//   cap            : i2s_capture_if master (pair, valid/ready, overrun, state)
// Optional (macro I2S_CAPTURE_FRAME_ERR_EN):
//   frame_err      : one-clk pulse per short-word discard
//   err_cnt        : saturating count of short-word discards
// -----------------------------------------------------------------------------
module i2s_capture
  import i2s_pkg::*;
#(
  parameter int WORD_W      = I2S_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic ws,
  input  logic sdi,
  i2s_capture_if.master cap
`ifdef I2S_CAPTURE_FRAME_ERR_EN
  ,
  output logic       frame_err,
  output logic [7:0] err_cnt
`endif
);

  localparam int              CNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  logic w_rise, w_ws_s, w_sdi_s;

  i2s_sync #(.STAGES(SYNC_STAGES), .RISE_EN(1'b1)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(sclk), .q(w_rise));
  i2s_sync #(.STAGES(SYNC_STAGES), .RISE_EN(1'b0)) u_sync_ws (
    .clk(clk), .reset(reset), .d(ws), .q(w_ws_s));
  i2s_sync #(.STAGES(SYNC_STAGES), .RISE_EN(1'b0)) u_sync_sdi (
    .clk(clk), .reset(reset), .d(sdi), .q(w_sdi_s));

  cap_state_e        r_state, w_state_nxt;
  logic              r_ws_prev;
  logic [WORD_W-1:0] r_shift, r_left_hold, r_right_hold;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_left_good, r_pair_pend;
  logic [WORD_W-1:0] r_left_data, r_right_data;
  logic              r_valid, r_overrun;
  logic              w_in_slot, w_is_left;

  logic              w_edge, w_can_shift, w_word_done, w_short;
  logic [WORD_W-1:0] w_shift_in;
  logic [CNT_W-1:0]  w_cnt_inc;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ALIGN;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state. Every ws edge re-aligns to the slot named by ws,
  // whatever state we are in.
  always_comb begin
    w_state_nxt = r_state;
    if (w_rise && w_edge) w_state_nxt = w_ws_s ? RIGHT : LEFT;
  end

  // FSM: outputs
  always_comb begin
    w_in_slot = 1'b0;
    w_is_left = 1'b0;
    case (r_state)
      LEFT:    begin w_in_slot = 1'b1; w_is_left = 1'b1; end
      RIGHT:   w_in_slot = 1'b1;
      default: ;
    endcase
  end

  assign w_edge      = (w_ws_s != r_ws_prev);
  assign w_shift_in  = {r_shift[WORD_W-2:0], w_sdi_s};
  assign w_cnt_inc   = r_bit_cnt + CNT_W'(1);
  // The edge bit still belongs to the old slot, so it shifts like any other.
  assign w_can_shift = w_in_slot && (r_bit_cnt <= CNT_LAST);
  assign w_word_done = w_rise && w_can_shift && (r_bit_cnt == CNT_LAST);
  // Slot closes with fewer than WORD_W bits even after the edge bit.
  assign w_short     = w_rise && w_edge && w_in_slot && (r_bit_cnt < CNT_LAST);

  // Deserializer and pair assembly, advanced only on sclk rise cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ws_prev    <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_left_hold  <= '0;
      r_right_hold <= '0;
      r_left_good  <= 1'b0;
      r_pair_pend  <= 1'b0;
    end else begin
      r_pair_pend <= 1'b0;
      if (w_rise) begin
        r_ws_prev <= w_ws_s;
        if (w_word_done) begin
          if (w_is_left) begin
            r_left_hold <= w_shift_in;
            r_left_good <= 1'b1;
          end else begin
            // A right word without a good left word is dropped silently.
            r_right_hold <= w_shift_in;
            r_pair_pend  <= r_left_good;
            r_left_good  <= 1'b0;
          end
        end
        if (w_edge) begin
          r_shift   <= '0;
          r_bit_cnt <= '0;
          // Short word abandons the pair; a new left slot starts a fresh pair.
          if (w_short || !w_in_slot || !w_ws_s) r_left_good <= 1'b0;
        end else if (w_can_shift) begin
          r_shift   <= w_shift_in;
          r_bit_cnt <= w_cnt_inc;
        end
      end
    end
  end

  // Output register: pair is loaded one clk after the right word completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_left_data  <= '0;
      r_right_data <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (r_pair_pend) begin
      if (!r_valid || cap.ready) begin
        r_left_data  <= r_left_hold;
        r_right_data <= r_right_hold;
        r_valid      <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && cap.ready) begin
      r_valid <= 1'b0;
    end
  end

  assign cap.left_data  = r_left_data;
  assign cap.right_data = r_right_data;
  assign cap.valid      = r_valid;
  assign cap.overrun    = r_overrun;
  assign cap.state      = r_state;

`ifdef I2S_CAPTURE_FRAME_ERR_EN
  logic       r_frame_err;
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_frame_err <= w_short;
      if (w_short && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign frame_err = r_frame_err;
  assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: doc/i2s_capture.md
# i2s_capture

Slave-mode I2S receiver: the capture path for the same externally clocked I2S link that the tone player drives. It oversamples the external sclk/ws/sdi in the system clock domain and aligns to the word-select edge. Each channel's MSB-first word is deserialized. Every completed left/right pair is presented on a valid/ready output for downstream logic such as a loopback checker or sample buffer.

## Interface
- WORD_W, 16: bits captured per channel; extra slot bits are ignored.
- SYNC_STAGES, 2: flops in each input synchronizer (minimum 2).

- clk  input  1  system clock (PLL c0); all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  external bit clock, asynchronous to clk.
- ws  input  1  external word select; 0 = left, 1 = right.
- sdi  input  1  serial data, MSB first, I2S one-bit delay after ws edge.
- left_data  output  WORD_W  captured left word.
- right_data  output  WORD_W  captured right word.
- valid  output  1  pair available.
- ready  input  1  consumer accepts pair when valid && ready.
- overrun  output  1  sticky; a completed pair was dropped.

## Operation
- sclk, ws and sdi each pass through SYNC_STAGES flops. A sclk rise event (`rise`) is synchronized sclk = 1 with its previous value = 0. Only `rise` cycles advance state.
- On each `rise`, sample ws_s and sdi_s. ws_prev holds ws_s from the previous `rise`. An edge is ws_s != ws_prev.
- States (package enum):
  - ALIGN: reset state; waits for the first ws edge.
  - LEFT: ws = 0 slot.
  - RIGHT: ws = 1 slot.
- ALIGN: on a ws edge, go to LEFT if ws_s = 0, else RIGHT; clear bit_cnt and the shift register. The bit sampled on that edge is discarded.
- LEFT/RIGHT: on a non-edge `rise`, if bit_cnt < WORD_W, shift sdi_s into the LSB and increment bit_cnt. Otherwise ignore the bit (slot padding).
- The bit_cnt update is saturating: reaching WORD_W latches the word into the left or right holding register.
- On a ws edge in LEFT/RIGHT:
  - The edge bit is the old slot's last bit. Shift it in if bit_cnt < WORD_W, then evaluate completion.
  - Switch state to the new ws value, clear bit_cnt and the shift register.
  - A slot ending with fewer than WORD_W bits is a short word: it is discarded, and the pair in progress is abandoned.
- Pair completion happens when a right word completes with a good left word held. Then:
  - If valid = 0: load left_data/right_data and set valid.
  - If valid = 1 and ready = 0: drop the new pair and set overrun.
  - If valid = 1 and ready = 1 in the same cycle: accept the old pair and load the new pair; valid stays 1.
- A right word with no preceding good left word (e.g. the first frame after ALIGN entered RIGHT) is discarded silently.
- valid clears on valid && ready when no new pair arrives that cycle.
- Reset mid-frame: returns to ALIGN. The partial frame is lost and no pair is emitted until the next full left+right.

## Timing
- Reset values: left_data = 0, right_data = 0, valid = 0, overrun = 0, state ALIGN; synchronizers cleared.
- sclk high and low phases must each be ≥ 3 clk periods; faster sclk is unsupported (bits lost).
- Latency from the physical sclk rise carrying the last right bit to valid = 1 is SYNC_STAGES + 2 clk.
- left_data/right_data are stable while valid = 1 and change only on the load cycle.
- overrun clears only on reset.

## Configuration
- I2S_CAPTURE_FRAME_ERR_EN defined:
  - adds output frame_err (1 bit, reset 0);
  - frame_err pulses one clk on every short-word discard;
  - adds output err_cnt (8 bits, reset 0), saturating at 255.
- Undefined: no such ports; short words are discarded silently.

## Structure
- Shared package i2s_pkg holds:
  - the capture state enum (ALIGN, LEFT, RIGHT);
  - the default WORD_W constant of 16, shared with i2s_play.
- Sub-module i2s_sync: a SYNC_STAGES-deep synchronizer for one bit plus optional rise-edge output. It is instantiated three times; rise detection is enabled for sclk only.

## Test plan
- Reset, then frames of 32 sclk per slot with left = 16'hA5C3 and right = 16'h1234, sclk = clk/8, ready = 1 → first full frame gives valid pulse with left_data = A5C3, right_data = 1234. Padding bits are ignored.
- ready = 0 for two frames (L/R = 0001/0002 then 0003/0004) → first pair held, overrun = 1, second pair dropped. Raising ready accepts 0001/0002.
- Slots of exactly 16 sclk with the ws edge on the LSB rise, L = FFFF, R = 8000 → pair captured correctly.
- Left slot truncated to 10 bits, then normal R = 5555 → no valid for that frame. With the macro, frame_err pulses once and err_cnt = 1.
- Reset asserted mid right slot, then clean frame L = 0F0F, R = F0F0 → no stale pair; next valid carries 0F0F/F0F0.
- Start stimulus with ws = 1 (mid right slot) → the first right word is discarded; the first valid pair is the next complete left+right.
